// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator cabin/shaft plant.
package elevator_pkg;

  localparam int FLOORS        = 4;
  localparam int TRAVEL_CYCLES = 8;
  localparam int DOOR_CYCLES   = 4;
  localparam int FLOOR_W       = $clog2(FLOORS);

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    MOVING       = 3'd1,
    DOOR_OPENING = 3'd2,
    DOOR_OPEN    = 3'd3,
    DOOR_CLOSING = 3'd4
  } cabin_state_t;

  // A single floor step is legal unless it would leave the shaft.
  function automatic logic step_legal(input int floor_idx, input logic up, input int floors);
    return up ? (floor_idx < floors - 1) : (floor_idx > 0);
  endfunction

endpackage

// File: rtl/plant_timer.sv
// Loadable down-counter shared by travel and door strokes; done while count is zero.
module plant_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_cnt <= '0;
    else if (i_load)          r_cnt <= i_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/cabin_plant.sv
// Elevator cabin/shaft plant: turns motor/door commands into floor, arrival and door status.
// Optional CABIN_FAULT_EN compiles in the sticky fault flag and its fault_clr input.
module cabin_plant
  import elevator_pkg::*;
#(
  parameter int FLOORS        = elevator_pkg::FLOORS,
  parameter int TRAVEL_CYCLES = elevator_pkg::TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = elevator_pkg::DOOR_CYCLES,
  parameter int RESET_FLOOR   = 0,
  localparam int FW           = (FLOORS > 2) ? $clog2(FLOORS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          motor_en,
  input  logic          SubeBaja,
  input  logic          AbreCierra,
`ifdef CABIN_FAULT_EN
  input  logic          fault_clr,
`endif
  output logic [FW-1:0] PActual,
  output logic          floor_arrive,
  output logic          moving,
  output logic          door_open,
  output logic          fault
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);

  cabin_state_t  r_state, w_next;
  logic [FW-1:0] r_floor, w_floor_nxt, w_floor_step;
  logic          r_dir, w_dir_nxt;
  logic          r_arrive, w_arrive_nxt;
  logic          r_moving, r_door;
  logic          w_fault_set;
  logic          w_tmr_load, w_tmr_done;
  logic [TW-1:0] w_tmr_val;
  logic          w_req_legal, w_cont_legal;

  assign w_floor_step = r_dir ? r_floor + 1'b1 : r_floor - 1'b1;
  assign w_req_legal  = step_legal(int'(r_floor), SubeBaja, FLOORS);
  // Whether the segment after the one just finishing may start.
  assign w_cont_legal = step_legal(int'(w_floor_step), r_dir, FLOORS);

  plant_timer #(.W(TW)) u_tmr (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_done (w_tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_floor  <= FW'(RESET_FLOOR);
      r_dir    <= 1'b0;
      r_arrive <= 1'b0;
      r_moving <= 1'b0;
      r_door   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_floor  <= w_floor_nxt;
      r_dir    <= w_dir_nxt;
      r_arrive <= w_arrive_nxt;
      r_moving <= (w_next == MOVING);
      r_door   <= (w_next inside {DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING});
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = TRAVEL_LD;
    unique case (r_state)
      IDLE: begin
        // Door command has priority over a simultaneous move request.
        if (AbreCierra) begin
          w_next     = DOOR_OPENING;
          w_tmr_load = 1'b1;
          w_tmr_val  = DOOR_LD;
        end else if (motor_en && w_req_legal) begin
          w_next     = MOVING;
          w_tmr_load = 1'b1;
        end
      end
      MOVING: begin
        if (w_tmr_done) begin
          if (motor_en && w_cont_legal) w_tmr_load = 1'b1;
          else                          w_next     = IDLE;
        end
      end
      DOOR_OPENING: begin
        if (w_tmr_done) w_next = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        if (!AbreCierra) begin
          w_next     = DOOR_CLOSING;
          w_tmr_load = 1'b1;
          w_tmr_val  = DOOR_LD;
        end
      end
      DOOR_CLOSING: begin
        if (AbreCierra) begin
          w_next     = DOOR_OPENING;
          w_tmr_load = 1'b1;
          w_tmr_val  = DOOR_LD;
        end else if (w_tmr_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_floor_nxt  = r_floor;
    w_dir_nxt    = r_dir;
    w_arrive_nxt = 1'b0;
    w_fault_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!AbreCierra && motor_en && w_req_legal) w_dir_nxt = SubeBaja;
        w_fault_set = motor_en && (AbreCierra || !w_req_legal);
      end
      MOVING: begin
        if (w_tmr_done) begin
          w_floor_nxt  = w_floor_step;
          w_arrive_nxt = 1'b1;
        end
      end
      DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING: w_fault_set = motor_en;
      default: ;
    endcase
  end

`ifdef CABIN_FAULT_EN
  logic r_fault;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_fault <= 1'b0;
    else if (w_fault_set) r_fault <= 1'b1;
    else if (fault_clr)   r_fault <= 1'b0;
  end
  assign fault = r_fault;
`else
  logic w_unused_fault;
  assign w_unused_fault = w_fault_set;
  assign fault          = 1'b0;
`endif

  assign PActual      = r_floor;
  assign floor_arrive = r_arrive;
  assign moving       = r_moving;
  assign door_open    = r_door;

endmodule

// File: tb/tb_cabin_plant.sv
// Bench for cabin_plant: directed scenarios with literal expectations plus random
// command traffic checked each cycle against a time-to-event model of the cabin.
module tb_cabin_plant;

  localparam int NF = 4;
  localparam int TC = 8;
  localparam int DC = 4;
`ifdef CABIN_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, motor_en = 1'b0, SubeBaja = 1'b0, AbreCierra = 1'b0, fault_clr = 1'b0;
  elevator_pkg::floor_t PActual;
  logic floor_arrive, moving, door_open, fault;

  always #5 clk = ~clk;

  cabin_plant dut (
    .clk          (clk),
    .reset        (reset),
    .motor_en     (motor_en),
    .SubeBaja     (SubeBaja),
    .AbreCierra   (AbreCierra),
`ifdef CABIN_FAULT_EN
    .fault_clr    (fault_clr),
`endif
    .PActual      (PActual),
    .floor_arrive (floor_arrive),
    .moving       (moving),
    .door_open    (door_open),
    .fault        (fault)
  );

  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;
  bit prev_arr = 1'b0;
  int arrs[$];
  int p_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycles remaining until the next arrival / end of door stroke.
  int m_floor, m_left, m_door, m_dleft; // m_door: 0 shut, 1 opening, 2 open, 3 closing
  bit m_dir, m_arr, m_fault;

  function automatic bit legal(input int f, input bit up);
    return up ? (f < NF - 1) : (f > 0);
  endfunction

  task automatic m_reset();
    m_floor = 0; m_left = 0; m_door = 0; m_dleft = 0;
    m_dir = 1'b0; m_arr = 1'b0; m_fault = 1'b0;
  endtask

  task automatic m_step();
    bit set;
    set   = 1'b0;
    m_arr = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_floor += m_dir ? 1 : -1;
        m_arr = 1'b1;
        if (motor_en && legal(m_floor, m_dir)) m_left = TC;
      end
    end else if (m_door != 0) begin
      set = motor_en;
      case (m_door)
        1: begin m_dleft--; if (m_dleft == 0) m_door = 2; end
        2: if (!AbreCierra) begin m_door = 3; m_dleft = DC; end
        3: if (AbreCierra) begin m_door = 1; m_dleft = DC; end
           else begin m_dleft--; if (m_dleft == 0) m_door = 0; end
        default: ;
      endcase
    end else if (AbreCierra) begin
      m_door = 1; m_dleft = DC; set = motor_en;
    end else if (motor_en) begin
      if (legal(m_floor, SubeBaja)) begin m_dir = SubeBaja; m_left = TC; end
      else set = 1'b1;
    end
    if (FEN) begin
      if (set) m_fault = 1'b1;
      else if (fault_clr) m_fault = 1'b0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else        m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_PActual", PActual, m_floor);
        chk("m_arrive", floor_arrive, m_arr);
        chk("m_moving", moving, m_left > 0);
        chk("m_door_open", door_open, m_door != 0);
        chk("m_fault", fault, m_fault);
        chk("arrive_consec", prev_arr & floor_arrive, 0);
        prev_arr = floor_arrive;
      end
    end
  end

  initial begin
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_floor", PActual, 0);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_arrive", floor_arrive, 0);
    reset = 1'b1;
    @(posedge clk); #2;

    // Up three floors from 0; motor held past the top.
    motor_en = 1'b1; SubeBaja = 1'b1;
    for (int i = 0; i <= 25; i++) begin
      @(posedge clk); #2;
      if (floor_arrive) arrs.push_back(i);
      if (i == 0)  chk("up_moving", moving, 1);
      if (i == 8)  chk("up_f1", PActual, 1);
      if (i == 16) chk("up_f2", PActual, 2);
      if (i == 24) begin chk("up_f3", PActual, 3); chk("up_idle", moving, 0); end
      if (i == 25) begin chk("top_fault", fault, FEN); chk("top_floor", PActual, 3); chk("top_still", moving, 0); end
    end
    chk("arr_cnt", arrs.size(), 3);
    chk("arr0", arrs.size() > 0 ? arrs[0] : -1, 8);
    chk("arr1", arrs.size() > 1 ? arrs[1] : -1, 16);
    chk("arr2", arrs.size() > 2 ? arrs[2] : -1, 24);
    motor_en = 1'b0; fault_clr = 1'b1;
    @(posedge clk); #2;
    fault_clr = 1'b0;
    chk("fault_clr", fault, 0);

    // Return to floor 0 via reset, then drop motor mid-segment.
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    motor_en = 1'b1; SubeBaja = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      @(posedge clk); #2;
      if (i == 2) motor_en = 1'b0;
      if (i == 7) begin chk("drop_f0", PActual, 0); chk("drop_mov", moving, 1); end
      if (i == 8) begin chk("drop_f1", PActual, 1); chk("drop_arr", floor_arrive, 1); chk("drop_idle", moving, 0); end
    end

    // Door open then close.
    AbreCierra = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk); #2;
      if (i == 0) chk("door_start", door_open, 1);
      if (i == 4) AbreCierra = 1'b0;
      if (i == 8) chk("door_hold", door_open, 1);
      if (i == 9) chk("door_shut", door_open, 0);
    end

    // Safety reopen during closing.
    AbreCierra = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      @(posedge clk); #2;
      if (i == 4)  AbreCierra = 1'b0;
      if (i == 6)  AbreCierra = 1'b1;
      if (i == 11) AbreCierra = 1'b0;
      if (i == 15) chk("reopen_hold", door_open, 1);
      if (i == 16) chk("reopen_shut", door_open, 0);
    end

    // Motor request while the door is open.
    p_hold = PActual;
    AbreCierra = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(posedge clk); #2;
      if (i == 5) motor_en = 1'b1;
      if (i == 6) begin
        chk("dm_floor", PActual, p_hold);
        chk("dm_moving", moving, 0);
        chk("dm_fault", fault, FEN);
        chk("dm_door", door_open, 1);
        motor_en = 1'b0; AbreCierra = 1'b0;
      end
    end

    // Asynchronous reset between floors 1 and 2.
    motor_en = 1'b1; SubeBaja = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #2;
    end
    chk("mid_floor", PActual, 1);
    chk("mid_moving", moving, 1);
    reset = 1'b0;
    #1;
    chk("ar_floor", PActual, 0);
    chk("ar_moving", moving, 0);
    chk("ar_arrive", floor_arrive, 0);
    chk("ar_door", door_open, 0);
    chk("ar_fault", fault, 0);
    @(posedge clk); #2;
    reset = 1'b1; motor_en = 1'b0;

    // Random command traffic.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0) motor_en = ~motor_en;
      if ($urandom_range(0, 7) == 0) SubeBaja = ~SubeBaja;
      if ($urandom_range(0, 7) == 0) AbreCierra = ~AbreCierra;
      fault_clr = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 399) != 0);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cabin_plant.md
# cabin_plant

Behavioural-synthesizable model of the elevator cabin and shaft: the plant end of the controller's command interface. It consumes the motor and door commands the elevator controller drives (`SubeBaja`, `AbreCierra`, motor enable) and produces the signals the controller reads back: current floor, one-cycle floor-arrival pulse and door status. This closes the loop on-chip and in simulation, replacing hand-driven floor and arrival stimulus.

## Interface
Parameters:
- `FLOORS`, 4: number of floors; floor index width is 2 bits for the default.
- `TRAVEL_CYCLES`, 8: clock cycles to travel one floor; must be ≥ 2.
- `DOOR_CYCLES`, 4: clock cycles for a full door open or close stroke; must be ≥ 2.
- `RESET_FLOOR`, 0: floor index loaded at reset.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: reset, asynchronous and active-low.
- `motor_en` in 1: request to move the cabin.
- `SubeBaja` in 1: direction, 1 = up, 0 = down.
- `AbreCierra` in 1: door command, 1 = open, 0 = close.
- `fault_clr` in 1: clears sticky fault; present only with `CABIN_FAULT_EN`.
- `PActual` out 2: current floor index.
- `floor_arrive` out 1: one-cycle pulse when the cabin reaches a new floor.
- `moving` out 1: cabin is between floors.
- `door_open` out 1: door not fully closed.
- `fault` out 1: sticky illegal-command flag.

## Operation
- States: IDLE, MOVING, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING. One down-counter `tmr` is shared by all timed states.
- Reset values: state IDLE, `PActual`=`RESET_FLOOR`, all other outputs 0, `tmr`=0. Reset may be asserted mid-travel or mid-stroke; the cabin returns to `RESET_FLOOR` with the door closed.
- IDLE, `motor_en`=1, `AbreCierra`=0, move is legal:
  - Latch `SubeBaja`, load `tmr`=`TRAVEL_CYCLES`-1, go to MOVING, set `moving`=1.
  - A move is legal unless it is up at floor `FLOORS`-1 or down at floor 0.
- IDLE, illegal move: stay in IDLE, `PActual` unchanged, raise `fault`.
- MOVING: decrement `tmr`. At `tmr`=0:
  - `PActual` steps ±1 per the latched direction; `floor_arrive` is 1 for that cycle.
  - If `motor_en`=1 and the next step is legal: reload `tmr` and continue.
  - Otherwise: go to IDLE and set `moving`=0.
- MOVING, other rules:
  - Deasserting `motor_en` mid-segment does not stop the cabin between floors; the segment completes.
  - A `SubeBaja` change mid-segment is ignored.
- IDLE, `AbreCierra`=1: load `tmr`=`DOOR_CYCLES`-1 and go to DOOR_OPENING. `door_open`=1 from entry into DOOR_OPENING until return to IDLE.
- DOOR_OPENING → DOOR_OPEN at `tmr`=0.
- DOOR_OPEN, `AbreCierra`=0: reload `tmr` and go to DOOR_CLOSING. At `tmr`=0, go to IDLE and set `door_open`=0.
- DOOR_CLOSING, `AbreCierra`=1: reverses to DOOR_OPENING with `tmr` reloaded (safety reopen).
- IDLE with `motor_en`=1 and `AbreCierra`=1 together: the door wins and `fault` is raised.
- `motor_en`=1 in any door state: ignored and `fault` is raised.
- `fault`: sticky; cleared only by `fault_clr` or by reset. If a set condition and `fault_clr` occur in the same cycle, set wins.

## Timing
- All outputs are registered; nothing is combinational from the inputs.
- `motor_en` sampled at edge k → `moving`=1 after edge k.
- First `PActual` change and `floor_arrive` pulse after edge k+`TRAVEL_CYCLES`; each further floor arrives every `TRAVEL_CYCLES` cycles.
- `AbreCierra` rising, sampled at edge k in IDLE → DOOR_OPEN after edge k+`DOOR_CYCLES`.
- Close: `door_open`=0 exactly `DOOR_CYCLES` cycles after `AbreCierra`=0 is sampled in DOOR_OPEN.
- `floor_arrive` is never high for two consecutive cycles.

## Configuration
- `CABIN_FAULT_EN` defined: fault detection, the `fault` register and the `fault_clr` port are compiled in.
- `CABIN_FAULT_EN` undefined:
  - `fault` is tied 0 and `fault_clr` is absent.
  - Illegal moves and commands are silently ignored.
  - State behaviour is otherwise identical.

## Structure
- Package `elevator_pkg`:
  - State enum `cabin_state_t`.
  - Floor index type `floor_t`.
  - Default constants `FLOORS`, `TRAVEL_CYCLES`, `DOOR_CYCLES`.
- One sub-module, `plant_timer`: the loadable down-counter with a `done` flag. It is instantiated once and shared by the motion and door states.

## Test plan
All scenarios use the default parameters.
- Reset, then `motor_en`=1 and `SubeBaja`=1 held for 24 cycles:
  - `floor_arrive` pulses after edges 8, 16 and 24.
  - `PActual` steps 1, 2, 3, then IDLE with `moving`=0.
- At floor 3, `motor_en`=1 and `SubeBaja`=1: no motion and `fault`=1; `fault_clr` pulse → `fault`=0.
- From floor 0, go up, then drop `motor_en` at cycle 3 of the segment: arrival at floor 1 still occurs at cycle 8, then IDLE.
- Door cycle:
  - `AbreCierra`=1 → DOOR_OPEN after 4 cycles.
  - `AbreCierra`=0 → `door_open`=0 after 4 more cycles.
  - `AbreCierra`=1 reasserted during closing → back to DOOR_OPEN 4 cycles later.
- `motor_en`=1 with the door open: `PActual` unchanged, `moving`=0, `fault`=1.
- Reset asserted mid-travel between floors 1 and 2: `PActual`=0 and all flags 0 immediately, with no clock edge required.
